// File: rtl/illegal_opcode_trap_pkg.sv
// Shared types and constants for the illegal-opcode trap sequencer.
package pla_trap_pkg;

  localparam int DEF_OPC_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REQ,
    ST_HOLD
  } trap_state_t;

  localparam logic [1:0] CAUSE_NONE       = 2'b00;
  localparam logic [1:0] CAUSE_RSVD       = 2'b01;
  localparam logic [1:0] CAUSE_UNASSIGNED = 2'b10;

  // Top opcode bit marks the reserved encoding space.
  function automatic logic [1:0] cause_of(input logic opc_msb);
    return opc_msb ? CAUSE_RSVD : CAUSE_UNASSIGNED;
  endfunction

endpackage

// File: rtl/illegal_opcode_trap_if.sv
// Stage-1 / exception-controller signal bundle for the trap sequencer.
interface illegal_opcode_trap_if #(
  parameter int OPC_W = 10,
  parameter int CNT_W = 8
);
  logic             cpipe1_valid;
  logic [OPC_W-1:0] cpipe1_opc;
  logic             pillegalopc;
  logic             trap_ack;
  logic             pipe_stall;
  logic             pipe_flush;
  logic             trap_req;
  logic [OPC_W-1:0] trap_opc;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] illegal_count;

  modport master (
    output cpipe1_valid, cpipe1_opc, pillegalopc, trap_ack,
    input  pipe_stall, pipe_flush, trap_req, trap_opc, trap_cause, illegal_count
  );

  modport slave (
    input  cpipe1_valid, cpipe1_opc, pillegalopc, trap_ack,
    output pipe_stall, pipe_flush, trap_req, trap_opc, trap_cause, illegal_count
  );
endinterface

// File: rtl/illegal_opcode_trap_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   count_q <= '0;
    else if (inc && count_q != '1) count_q <= count_q + 1'b1;
  end

  assign count = count_q;
endmodule

// File: rtl/illegal_opcode_trap.sv
// Trap sequencer: on an accepted illegal opcode, flush, request trap, hold off.
module illegal_opcode_trap
  import pla_trap_pkg::*;
#(
  parameter int OPC_W   = DEF_OPC_W,
  parameter int CNT_W   = 8,
  parameter int HOLDOFF = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  illegal_opcode_trap_if.slave  bus
);
  localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF > 0 ? HOLDOFF - 1 : 0);

  trap_state_t      state_q;
  logic             stall_q, flush_q, req_q;
  logic [OPC_W-1:0] opc_q;
  logic [1:0]       cause_q;
  logic [3:0]       hold_q;
  logic             accept;

  assign accept = (state_q == ST_IDLE) && bus.cpipe1_valid && bus.pillegalopc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stall_q <= 1'b0;
      flush_q <= 1'b0;
      req_q   <= 1'b0;
      opc_q   <= '0;
      cause_q <= CAUSE_NONE;
      hold_q  <= '0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (accept) begin
          state_q <= ST_FLUSH;
          flush_q <= 1'b1;
          stall_q <= 1'b1;
          opc_q   <= bus.cpipe1_opc;
          cause_q <= cause_of(bus.cpipe1_opc[OPC_W-1]);
        end
        ST_FLUSH: begin
          state_q <= ST_REQ;
          req_q   <= 1'b1;
        end
        ST_REQ: if (bus.trap_ack) begin
          req_q <= 1'b0;
          if (HOLDOFF == 0) begin
            state_q <= ST_IDLE;
            stall_q <= 1'b0;
          end else begin
            state_q <= ST_HOLD;
            hold_q  <= HOLD_INIT;
          end
        end
        ST_HOLD: begin
          if (hold_q == '0) begin
            state_q <= ST_IDLE;
            stall_q <= 1'b0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .count (bus.illegal_count)
  );

  assign bus.pipe_stall = stall_q;
  assign bus.pipe_flush = flush_q;
  assign bus.trap_req   = req_q;
  assign bus.trap_opc   = opc_q;
  assign bus.trap_cause = cause_q;
endmodule
